// File: rtl/event_region_sched.sv
// event_region_sched: batches simultaneous requests into one step and drains them onto a single channel,
// active region first then deferred region, each in ascending index; two-region mode needs REGION_DEFER_EN.
module event_region_sched #(
  parameter int N_REQ = 4,
  parameter int DATA_W = 8,
  parameter int CNT_W = 16,
  localparam int ID_W = $clog2(N_REQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ-1:0]        req_defer,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        req_ack,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ID_W-1:0]         out_id,
  output logic [DATA_W-1:0]       out_data,
  output logic                    out_deferred,
  output logic                    busy,
  output logic                    step_done,
  output logic [CNT_W-1:0]        step_cnt
);
  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_DEFERRED, S_DONE} state_t;
  state_t r_state, w_next;
  logic [N_REQ-1:0] r_pend_act, r_pend_def, w_cap_act, w_cap_def, w_sel, w_sel_oh, w_rem;
  logic [N_REQ*DATA_W-1:0] r_data, w_cap_data;
  logic [CNT_W-1:0] r_step_cnt;
  logic w_capture, w_fire;
`ifdef REGION_DEFER_EN
  assign w_cap_act = req_valid & ~req_defer;
  assign w_cap_def = req_valid & req_defer;
  assign out_deferred = r_state == S_DEFERRED;
`else
  logic w_unused;
  assign w_cap_act = req_valid;
  assign w_cap_def = '0;
  assign out_deferred = 1'b0;
  assign w_unused = ^req_defer;
`endif
  assign w_capture = r_state == S_IDLE && |req_valid;
  assign req_ack = (r_state == S_IDLE && !rst) ? req_valid : '0;
  assign out_valid = r_state == S_ACTIVE || r_state == S_DEFERRED;
  assign busy = r_state != S_IDLE;
  assign step_done = r_state == S_DONE;
  assign step_cnt = r_step_cnt;
  assign w_sel = r_state == S_ACTIVE ? r_pend_act : r_state == S_DEFERRED ? r_pend_def : '0;
  // isolate the lowest set bit; what remains after it is the rest of the region
  assign w_sel_oh = w_sel & -w_sel;
  assign w_rem = w_sel & ~w_sel_oh;
  assign w_fire = out_valid && out_ready;
  assign out_data = out_valid ? r_data[out_id*DATA_W +: DATA_W] : '0;
  always_comb begin
    out_id = '0;
    for (int i = N_REQ - 1; i >= 0; i--) if (w_sel[i]) out_id = i[ID_W-1:0];
  end
  always_comb begin
    w_cap_data = '0;
    for (int i = 0; i < N_REQ; i++)
      w_cap_data[i*DATA_W +: DATA_W] = req_valid[i] ? req_data[i*DATA_W +: DATA_W] : '0;
  end
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:     w_next = !(|req_valid) ? S_IDLE : |w_cap_act ? S_ACTIVE : S_DEFERRED;
      S_ACTIVE:   w_next = (out_ready && w_rem == '0) ? (|r_pend_def ? S_DEFERRED : S_DONE) : S_ACTIVE;
      S_DEFERRED: w_next = (out_ready && w_rem == '0) ? S_DONE : S_DEFERRED;
      default:    w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_pend_act <= '0;
      r_pend_def <= '0;
      r_data <= '0;
      r_step_cnt <= '0;
    end else begin
      r_state <= w_next;
      if (w_capture) begin
        r_pend_act <= w_cap_act;
        r_pend_def <= w_cap_def;
        r_data <= w_cap_data;
      end else if (w_fire && r_state == S_ACTIVE) r_pend_act <= w_rem;
      else if (w_fire && r_state == S_DEFERRED) r_pend_def <= w_rem;
      if (r_state == S_DONE) r_step_cnt <= r_step_cnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_event_region_sched.sv
// tb_event_region_sched: directed checks of capture, region order, backpressure, busy arrival, reset and counter wrap.
module tb_event_region_sched;
`ifdef REGION_DEFER_EN
  localparam bit DEF_EN = 1'b1;
`else
  localparam bit DEF_EN = 1'b0;
`endif
  logic clk = 1'b0, rst, out_ready;
  logic [3:0] rv, rd, req_ack, w_ack2;
  logic [31:0] rdata;
  logic out_valid, out_deferred, busy, step_done;
  logic [1:0] out_id, w_id2, w_cnt2;
  logic [7:0] out_data, w_data2;
  logic [15:0] step_cnt;
  logic w_v2, w_def2, w_busy2, w_done2;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  event_region_sched dut (
    .clk(clk), .rst(rst), .req_valid(rv), .req_defer(rd), .req_data(rdata), .req_ack(req_ack),
    .out_valid(out_valid), .out_ready(out_ready), .out_id(out_id), .out_data(out_data),
    .out_deferred(out_deferred), .busy(busy), .step_done(step_done), .step_cnt(step_cnt));
  // narrow counter copy sees the same traffic so the wrap is reachable in a short run
  event_region_sched #(.CNT_W(2)) u_wrap (
    .clk(clk), .rst(rst), .req_valid(rv), .req_defer(rd), .req_data(rdata), .req_ack(w_ack2),
    .out_valid(w_v2), .out_ready(out_ready), .out_id(w_id2), .out_data(w_data2),
    .out_deferred(w_def2), .busy(w_busy2), .step_done(w_done2), .step_cnt(w_cnt2));
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask
  task automatic see(input string tag, input int id, input int d, input bit df);
    chk({tag, "_valid"}, 32'(out_valid), 1);
    chk({tag, "_id"}, 32'(out_id), id);
    chk({tag, "_data"}, 32'(out_data), d);
    chk({tag, "_def"}, 32'(out_deferred), 32'(df));
  endtask
  task automatic drain(input string tag, input int id, input int d, input bit df);
    see(tag, id, d, df);
    tick();
  endtask
  task automatic finish_step(input string tag, input int cnt);
    chk({tag, "_done"}, 32'(step_done), 1);
    chk({tag, "_done_nov"}, 32'(out_valid), 0);
    tick();
    chk({tag, "_done_pulse"}, 32'(step_done), 0);
    chk({tag, "_cnt"}, 32'(step_cnt), cnt);
    chk({tag, "_idle"}, 32'(busy), 0);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end
  initial begin
    rst = 1; rv = 4'hF; rd = 4'h0; out_ready = 1; rdata = 32'hD3C2B1A0;
    tick();
    chk("rst_ack", 32'(req_ack), 0);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(step_done), 0);
    chk("rst_cnt", 32'(step_cnt), 0);
    chk("rst_id", 32'(out_id), 0);
    chk("rst_data", 32'(out_data), 0);
    chk("rst_def", 32'(out_deferred), 0);
    tick();
    chk("rst2_ack", 32'(req_ack), 0);
    rst = 0; #1;
    chk("cap_all_ack", 32'(req_ack), 4'hF);
    tick(); rv = 0; #1;
    chk("cap_all_noack", 32'(req_ack), 0);
    drain("all0", 0, 8'hA0, 0);
    drain("all1", 1, 8'hB1, 0);
    drain("all2", 2, 8'hC2, 0);
    drain("all3", 3, 8'hD3, 0);
    finish_step("all", 1);
    rv = 4'b0011; rd = 4'b0001; rdata = 32'h0000B1A0; #1;
    chk("two_ack", 32'(req_ack), 4'b0011);
    tick(); rv = 0; rd = 0; #1;
    drain("two_a", DEF_EN ? 1 : 0, DEF_EN ? 8'hB1 : 8'hA0, 0);
    drain("two_b", DEF_EN ? 0 : 1, DEF_EN ? 8'hA0 : 8'hB1, DEF_EN);
    finish_step("two", 2);
    rv = 4'b1010; rd = 4'b1010; rdata = 32'hD300B100; #1;
    chk("alldef_ack", 32'(req_ack), 4'b1010);
    tick(); rv = 0; rd = 0; #1;
    drain("alldef_a", 1, 8'hB1, DEF_EN);
    drain("alldef_b", 3, 8'hD3, DEF_EN);
    finish_step("alldef", 3);
    rv = 4'b0100; rdata = 32'h005C0000; out_ready = 0; #1;
    chk("bp_ack", 32'(req_ack), 4'b0100);
    tick(); rv = 0; #1;
    for (int i = 0; i < 3; i++) begin
      see("bp_hold", 2, 8'h5C, 0);
      tick();
    end
    out_ready = 1; #1;
    drain("bp_go", 2, 8'h5C, 0);
    finish_step("bp", 4);
    chk("wrap_cnt", 32'(w_cnt2), 0);
    rv = 4'b0001; rdata = 32'h33000011; #1;
    chk("busy_ack0", 32'(req_ack), 4'b0001);
    tick(); rv = 4'b1000; #1;
    chk("busy_noack", 32'(req_ack), 0);
    drain("busy0", 0, 8'h11, 0);
    chk("busy_done_noack", 32'(req_ack), 0);
    chk("busy_done", 32'(step_done), 1);
    tick();
    chk("busy_cnt1", 32'(step_cnt), 5);
    chk("busy_ack3", 32'(req_ack), 4'b1000);
    tick(); rv = 0; #1;
    drain("busy3", 3, 8'h33, 0);
    finish_step("busy", 6);
    rv = 4'hF; rd = 4'b0011; rdata = 32'h44332211; #1;
    chk("mid_ack", 32'(req_ack), 4'hF);
    tick(); rv = 0; rd = 0; #1;
    drain("mid_a", DEF_EN ? 2 : 0, DEF_EN ? 8'h33 : 8'h11, 0);
    drain("mid_b", DEF_EN ? 3 : 1, DEF_EN ? 8'h44 : 8'h22, 0);
    see("mid_c", DEF_EN ? 0 : 2, DEF_EN ? 8'h11 : 8'h33, DEF_EN);
    rst = 1;
    tick();
    chk("mid_rst_valid", 32'(out_valid), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_data", 32'(out_data), 0);
    chk("mid_rst_cnt", 32'(step_cnt), 0);
    chk("mid_rst_ack", 32'(req_ack), 0);
    rst = 0; rv = 4'b0100; rdata = 32'h00770000; #1;
    chk("post_ack", 32'(req_ack), 4'b0100);
    tick(); rv = 0; #1;
    drain("post", 2, 8'h77, 0);
    finish_step("post", 1);
    chk("wrap_cnt_post", 32'(w_cnt2), 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/event_region_sched.md
# event_region_sched

Batch event scheduler that serializes simultaneous requests onto one shared output channel in a deterministic, two-region order. All requests captured in the same cycle form one time step. Non-deferred ("active") entries drain first, then deferred entries, each region in ascending requester index. This is the hardware counterpart of active versus zero-delay-deferred ordering. It sits between N event producers and a single downstream consumer, such as a log/trace sink.

## Interface
- `N_REQ`, 4: number of requesters (2..16)
- `DATA_W`, 8: payload width per request
- `CNT_W`, 16: width of completed-step counter
- `clk`  in  1  clock; all logic on rising edge
- `rst`  in  1  reset; synchronous, active-high
- `req_valid`  in  N_REQ  per-requester request; held until acked
- `req_defer`  in  N_REQ  per-requester deferred-region flag, sampled with req_valid
- `req_data`  in  N_REQ*DATA_W  payloads, requester i at [i*DATA_W +: DATA_W]
- `req_ack`  out  N_REQ  one-cycle pulse per captured requester
- `out_valid`  out  1  entry presented
- `out_ready`  in  1  consumer accepts when high with out_valid
- `out_id`  out  $clog2(N_REQ)  requester index of presented entry
- `out_data`  out  DATA_W  payload of presented entry
- `out_deferred`  out  1  presented entry is from deferred region
- `busy`  out  1  state != IDLE
- `step_done`  out  1  one-cycle pulse when a step fully drains
- `step_cnt`  out  CNT_W  completed steps, wraps

## Operation
- States: IDLE, ACTIVE, DEFERRED, DONE.
- IDLE, any req_valid:
  - latch `pend_act = req_valid & ~req_defer` and `pend_def = req_valid & req_defer`;
  - latch all valid payloads;
  - `req_ack = req_valid` this cycle.
  - Next state is ACTIVE if pend_act != 0, else DEFERRED.
- IDLE, no req_valid: stay; req_ack = 0.
- ACTIVE: present the lowest set index of pend_act. On handshake, clear that bit. When the last bit is cleared, go to DEFERRED if pend_def != 0, else DONE.
- DEFERRED: same as ACTIVE, using pend_def with out_deferred=1. When the last bit is cleared, go to DONE.
- DONE: step_done=1, step_cnt increments (wraps to 0 after max), then IDLE.
- req_valid in any state other than IDLE is ignored and not acked. Requesters hold the request, and it is captured in the next IDLE cycle.
- Output decode:
  - out_valid = state is ACTIVE or DEFERRED; by construction pending is nonzero there.
  - out_id, out_data and out_deferred come combinationally from registered pending and payload state. They are 0 when out_valid=0.

## Timing
- Reset values: state IDLE; pend_act, pend_def and payload regs 0; req_ack 0; out_valid 0; out_id 0; out_data 0; out_deferred 0; busy 0; step_done 0; step_cnt 0.
- Capture at edge T puts out_valid high after T; first entry is acceptable in cycle T+1.
- One entry per cycle while out_ready=1. A step of k entries occupies k drain cycles plus 1 DONE cycle. Capture of the next step occurs at earliest 1 cycle after DONE (IDLE).
- Backpressure: while out_valid && !out_ready, out_id, out_data and out_deferred are held stable.
- No bubble between regions: the cycle after the last active handshake presents the first deferred entry.
- rst mid-step: all pending entries are discarded. Outputs are at reset values the cycle after rst is sampled. Uncaptured requesters are unaffected and captured after reset.
- req_defer is ignored for requesters where req_valid=0.

## Configuration
- `REGION_DEFER_EN` defined: two-region ordering as above.
- `REGION_DEFER_EN` undefined:
  - req_defer is ignored and all captured entries go to pend_act;
  - order is purely ascending index;
  - DEFERRED state is never entered;
  - out_deferred is tied 0.

## Test plan
- Reset: hold rst 2 cycles with req_valid=4'hF → all outputs 0, no ack; after release, capture in first IDLE cycle with req_ack=4'hF.
- Two-region order: req_valid=4'b0011, req_defer=4'b0001, data0=8'hA0, data1=8'hB1, out_ready=1 → out (id1,B1,def0) then (id0,A0,def1), step_done pulse, step_cnt=1. With macro undefined → id0 then id1, out_deferred=0.
- All-deferred: req_valid=4'b1010, req_defer=4'b1010 → DEFERRED directly, order id1, id3, no ACTIVE cycle.
- Backpressure: single request id2 data=8'h5C, out_ready=0 for 3 cycles → out_valid=1 with id2/5C held; handshake on cycle 4; DONE next cycle.
- Busy arrival: req0 captured, and req3 asserted while busy → req3 not acked until the cycle after DONE, then sent as its own step; step_cnt increments twice.
- Reset mid-DEFERRED and wrap: assert rst during deferred drain → out_valid=0 next cycle, remaining entries lost. Preload 0xFFFF completed steps (CNT_W=16) → next DONE gives step_cnt=0.
